// File: rtl/int_collect_pkg.sv
// Shared constants for the interrupt collector: output FSM encoding, entry width, pointer-width helper.
package int_collect_pkg;

    localparam logic [1:0] O_IDLE     = 2'b00;
    localparam logic [1:0] O_REQ      = 2'b01;
    localparam logic [1:0] O_WAIT_LOW = 2'b10;

    localparam int SRCW = 64;
    localparam int CTXW_DFLT = 9;
    localparam int ENTW = SRCW + CTXW_DFLT;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/int_collect_fifo.sv
// Synchronous FIFO holding {source, context} entries; pointers carry an extra wrap bit for full/empty.
// With INT_COALESCE_EN defined it also exposes the most recently written entry.
module int_collect_fifo
    import int_collect_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = ENTW
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic [W-1:0]            head,
`ifdef INT_COALESCE_EN
    output logic [W-1:0]            last_entry,
    output logic                    last_valid,
`endif
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);
    localparam int PW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW:0]   wptr;
    logic [PW:0]   rptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    // Storage is not reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[PW-1:0]] <= push_data;
    end

    assign head  = mem[rptr[PW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign level = wptr - rptr;

`ifdef INT_COALESCE_EN
    logic [PW-1:0] last_idx;
    assign last_idx   = wptr[PW-1:0] - 1'b1;
    assign last_entry = mem[last_idx];
    // The newest entry is popped last, so it is still queued whenever the FIFO is non-empty.
    assign last_valid = !empty;
`endif

endmodule

// File: rtl/interrupt_collector.sv
// Round-robin collection of per-source interrupt requests into a FIFO, issued one at a time on a
// four-phase req/ack handshake. Optional INT_COALESCE_EN drops a request equal to the newest queued entry.
module interrupt_collector
    import int_collect_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int CTXW  = 9,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NSRC-1:0]           src_valid,
    output logic [NSRC-1:0]           src_ready,
    input  logic [NSRC*64-1:0]        src_data,
    input  logic [NSRC*CTXW-1:0]      src_ctx,
    output logic                      interrupt_req,
    output logic [63:0]               interrupt_src,
    output logic [CTXW-1:0]           interrupt_ctx,
    input  logic                      interrupt_ack,
    output logic [clog2(DEPTH):0]     fifo_level,
    output logic [31:0]               issued_cnt
);
    localparam int EW  = 64 + CTXW;
    localparam int RRW = (NSRC > 1) ? clog2(NSRC) : 1;

    logic [RRW-1:0] rr_ptr;
    logic [RRW-1:0] gnt_idx;
    logic           gnt_any;
    logic           xfer;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [EW-1:0]  entry;
    logic [EW-1:0]  head;
    logic [1:0]     state;
    logic [1:0]     state_next;
    logic           drop_req;
    logic           inc_cnt;

    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(rr_ptr) + k) % NSRC;
            if (!gnt_any && src_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = RRW'(idx);
            end
        end
    end

    assign xfer      = gnt_any && !full && resetn;
    assign src_ready = xfer ? (NSRC'(1) << gnt_idx) : '0;
    assign entry     = {src_data[64*gnt_idx +: 64], src_ctx[CTXW*gnt_idx +: CTXW]};

`ifdef INT_COALESCE_EN
    logic [EW-1:0] last_entry;
    logic          last_valid;
    // Duplicate of the newest queued entry is acknowledged but not stored.
    assign push = xfer && !(last_valid && (last_entry == entry));
`else
    assign push = xfer;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rr_ptr <= '0;
        else if (xfer) rr_ptr <= (gnt_idx == RRW'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
    end

    int_collect_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
`ifdef INT_COALESCE_EN
        .last_entry(last_entry),
        .last_valid(last_valid),
`endif
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= O_IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            O_IDLE:     if (!empty && !interrupt_ack) state_next = O_REQ;
            O_REQ:      if (interrupt_ack) state_next = O_WAIT_LOW;
            O_WAIT_LOW: if (!interrupt_ack) state_next = O_IDLE;
            default:    state_next = O_IDLE;
        endcase
    end

    // Head is popped only when leaving O_IDLE, never while ack is still high.
    always_comb begin
        pop      = (state == O_IDLE) && !empty && !interrupt_ack;
        drop_req = (state == O_REQ) && interrupt_ack;
        inc_cnt  = (state == O_WAIT_LOW) && !interrupt_ack;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            interrupt_req <= 1'b0;
            interrupt_src <= '0;
            interrupt_ctx <= '0;
            issued_cnt    <= '0;
        end else begin
            if (pop) begin
                interrupt_req <= 1'b1;
                interrupt_src <= head[EW-1:CTXW];
                interrupt_ctx <= head[CTXW-1:0];
            end else if (drop_req) begin
                interrupt_req <= 1'b0;
            end
            if (inc_cnt) issued_cnt <= issued_cnt + 1'b1;
        end
    end

endmodule
